// File: rtl/flash_led_sched.sv
// LED flasher scheduler: power/pause FSM, speed-selectable step strobe and
// shift-direction control for a downstream 8-LED shifter.
module flash_led_sched #(
  parameter int unsigned DIV0   = 50_000_000,
  parameter int unsigned DIV1   = 25_000_000,
  parameter int unsigned DIV2   = 12_500_000,
  parameter int unsigned DIV3   = 6_250_000,
  parameter int unsigned SWEEPS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_btn,
  input  logic       pause_btn,
  input  logic [1:0] speed_sel,
  input  logic [1:0] mode_sel,
  output logic       clk_bps,
  output logic       dir,
  output logic       power_now,
  output logic       paused
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [15:0] SWEEPS_W = 16'(SWEEPS);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  pwr_sync;
  logic [2:0]  pse_sync;
  logic [1:0]  warm;
  logic        pwr_armed;
  logic        pse_armed;
  logic        pwr_press;
  logic        pse_press;
  logic        start;
  logic [1:0]  speed_q;
  logic [1:0]  mode_q;
  logic        speed_chg;
  logic [31:0] div;
  logic [31:0] tick;
  logic [2:0]  step;
  logic [15:0] sweep;

  // Buttons are only armed once the synchronizer holds a real sample and it
  // reads low, so a level held high through reset release is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_sync  <= '0;
      pse_sync  <= '0;
      warm      <= '0;
      pwr_armed <= 1'b0;
      pse_armed <= 1'b0;
    end else begin
      pwr_sync <= {pwr_sync[1:0], power_btn};
      pse_sync <= {pse_sync[1:0], pause_btn};
      warm     <= {warm[0], 1'b1};
      if (warm[1] && !pwr_sync[1]) pwr_armed <= 1'b1;
      if (warm[1] && !pse_sync[1]) pse_armed <= 1'b1;
    end
  end

  assign pwr_press = pwr_sync[1] & ~pwr_sync[2] & pwr_armed;
  assign pse_press = pse_sync[1] & ~pse_sync[2] & pse_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OFF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pwr_press) begin
      state_nxt = (state == OFF) ? RUN : OFF;
    end else if (pse_press) begin
      if (state == RUN)        state_nxt = PAUSE;
      else if (state == PAUSE) state_nxt = RUN;
    end
  end

  always_comb begin
    case (speed_sel)
      2'd0:    div = 32'(DIV0);
      2'd1:    div = 32'(DIV1);
      2'd2:    div = 32'(DIV2);
      default: div = 32'(DIV3);
    endcase
  end

  assign start     = (state == OFF) && (state_nxt == RUN);
  assign speed_chg = (speed_sel != speed_q);
  assign clk_bps   = (state == RUN) && !speed_chg && (tick == div - 32'd1);
  assign power_now = (state != OFF);
  assign paused    = (state == PAUSE);

  // A speed change while paused also clears the held count so it can never
  // sit above the new terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= '0;
      tick    <= '0;
    end else begin
      speed_q <= speed_sel;
      if (state_nxt == OFF) begin
        tick <= '0;
      end else if (state == RUN) begin
        if (speed_chg || clk_bps) tick <= '0;
        else                      tick <= tick + 32'd1;
      end else if (state == PAUSE && speed_chg) begin
        tick <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      step   <= '0;
      sweep  <= '0;
      dir    <= 1'b0;
    end else if (start) begin
      mode_q <= mode_sel;
      step   <= '0;
      sweep  <= '0;
      dir    <= (mode_sel == 2'b01);
    end else if (clk_bps) begin
      case (mode_q)
        2'b10: begin
          // Ping-pong reuses the step counter as a 7-strobe period.
          if (step == 3'd6) begin
            step <= '0;
            dir  <= ~dir;
          end else begin
            step <= step + 3'd1;
          end
        end
        2'b11: begin
          step <= step + 3'd1;
          if (step == 3'd7) begin
            if (sweep + 16'd1 == SWEEPS_W) begin
              sweep <= '0;
              dir   <= ~dir;
            end else begin
              sweep <= sweep + 16'd1;
            end
          end
        end
        default: step <= step + 3'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_led_sched.sv
// Scoreboard bench for flash_led_sched: stimulus queues expected strobes and
// status samples by cycle number; a negedge monitor pops and compares them.
module tb_flash_led_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [1:0] speed_sel = 2'd2;
  logic [1:0] mode_sel = 2'd0;
  logic       clk_bps;
  logic       dir;
  logic       power_now;
  logic       paused;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int   c;
    logic d;
  } strobe_t;

  typedef struct {
    int   c;
    logic bps;
    logic pn;
    logic pa;
    logic d;
  } status_t;

  strobe_t exp_sb[$];
  status_t exp_st[$];

  flash_led_sched #(
    .DIV0(16),
    .DIV1(8),
    .DIV2(4),
    .DIV3(3),
    .SWEEPS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .power_btn(power_btn),
    .pause_btn(pause_btn),
    .speed_sel(speed_sel),
    .mode_sel(mode_sel),
    .clk_bps(clk_bps),
    .dir(dir),
    .power_now(power_now),
    .paused(paused)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
  endtask

  task automatic sb(input int c, input logic d);
    strobe_t s;
    s.c = c;
    s.d = d;
    exp_sb.push_back(s);
  endtask

  task automatic st(input int c, input logic bps, input logic pn, input logic pa, input logic d);
    status_t t;
    t.c   = c;
    t.bps = bps;
    t.pn  = pn;
    t.pa  = pa;
    t.d   = d;
    exp_st.push_back(t);
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic pw, input logic pa);
    if (pw) power_btn = 1'b1;
    if (pa) pause_btn = 1'b1;
    at_cyc(cyc + 4);
    power_btn = 1'b0;
    pause_btn = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    strobe_t s;
    status_t t;
    if (clk_bps) begin
      if (exp_sb.size() == 0) begin
        check("strobe_unexpected", cyc, -1);
      end else begin
        s = exp_sb.pop_front();
        check("strobe_cycle", cyc, s.c);
        check("strobe_dir", int'(dir), int'(s.d));
      end
    end
    while (exp_st.size() > 0 && exp_st[0].c <= cyc) begin
      t = exp_st.pop_front();
      check("status_cycle", cyc, t.c);
      check("status_clk_bps", int'(clk_bps), int'(t.bps));
      check("status_power_now", int'(power_now), int'(t.pn));
      check("status_paused", int'(paused), int'(t.pa));
      check("status_dir", int'(dir), int'(t.d));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    st(2, 0, 0, 0, 0);
    at_cyc(3);
    rst_n = 1'b1;

    // Mode 00, speed 2: power on at 3rd edge, strobe every 4 clocks.
    c0 = 10;
    at_cyc(c0);
    st(c0 + 2, 0, 0, 0, 0);
    st(c0 + 3, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) sb(c0 + 6 + 4 * k, 1'b0);
    st(c0 + 30, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    at_cyc(c0 + 27);
    press(1'b1, 1'b0);

    // Mode 10, speed 3: dir toggles with strobes #7, #14, #21.
    at_cyc(c0 + 35);
    mode_sel  = 2'd2;
    speed_sel = 2'd3;
    c0 = c0 + 40;
    at_cyc(c0);
    for (int k = 0; k < 23; k++) sb(c0 + 5 + 3 * k, ((k / 7) % 2) == 1);
    st(c0 + 65, 1, 1, 0, 0);
    st(c0 + 66, 0, 1, 0, 1);
    st(c0 + 73, 0, 0, 0, 1);
    press(1'b1, 1'b0);
    at_cyc(c0 + 69);
    press(1'b1, 1'b0);

    // Mode 11: 16 strobes per direction; dir cleared on power-on.
    at_cyc(c0 + 76);
    mode_sel = 2'd3;
    c0 = c0 + 80;
    at_cyc(c0);
    st(c0 + 3, 0, 1, 0, 0);
    for (int k = 0; k < 41; k++) sb(c0 + 5 + 3 * k, ((k / 16) % 2) == 1);
    st(c0 + 127, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    at_cyc(c0 + 123);
    press(1'b1, 1'b0);

    // Pause holding tick=2 for 20 clocks; mode change mid-run has no effect.
    at_cyc(c0 + 130);
    mode_sel  = 2'd0;
    speed_sel = 2'd2;
    c0 = c0 + 135;
    at_cyc(c0);
    sb(c0 + 6, 1'b0);
    sb(c0 + 30, 1'b0);
    sb(c0 + 34, 1'b0);
    sb(c0 + 38, 1'b0);
    st(c0 + 9, 0, 1, 1, 0);
    st(c0 + 28, 0, 1, 1, 0);
    st(c0 + 29, 0, 1, 0, 0);
    st(c0 + 42, 0, 0, 0, 0);
    press(1'b1, 1'b0);
    at_cyc(c0 + 6);
    press(1'b0, 1'b1);
    at_cyc(c0 + 12);
    mode_sel = 2'd1;
    at_cyc(c0 + 26);
    press(1'b0, 1'b1);
    at_cyc(c0 + 39);
    press(1'b1, 1'b0);

    // Mode 01; speed change 2->0 on a would-be strobe; simultaneous presses.
    at_cyc(c0 + 45);
    c0 = c0 + 50;
    at_cyc(c0);
    sb(c0 + 6, 1'b1);
    sb(c0 + 10, 1'b1);
    sb(c0 + 30, 1'b1);
    sb(c0 + 46, 1'b1);
    st(c0 + 14, 0, 1, 0, 1);
    st(c0 + 50, 0, 0, 0, 1);
    st(c0 + 51, 0, 0, 0, 1);
    press(1'b1, 1'b0);
    at_cyc(c0 + 14);
    speed_sel = 2'd0;
    at_cyc(c0 + 47);
    press(1'b1, 1'b1);

    // Reset mid-run with power_btn held high.
    at_cyc(c0 + 55);
    speed_sel = 2'd2;
    c0 = c0 + 60;
    at_cyc(c0);
    sb(c0 + 6, 1'b1);
    st(c0 + 7, 0, 1, 0, 1);
    st(c0 + 8, 0, 0, 0, 0);
    st(c0 + 20, 0, 0, 0, 0);
    st(c0 + 27, 0, 0, 0, 0);
    st(c0 + 28, 0, 1, 0, 1);
    sb(c0 + 31, 1'b1);
    st(c0 + 35, 0, 0, 0, 1);
    power_btn = 1'b1;
    at_cyc(c0 + 8);
    rst_n = 1'b0;
    at_cyc(c0 + 10);
    rst_n = 1'b1;
    at_cyc(c0 + 20);
    power_btn = 1'b0;
    at_cyc(c0 + 25);
    power_btn = 1'b1;
    at_cyc(c0 + 29);
    power_btn = 1'b0;
    at_cyc(c0 + 32);
    press(1'b1, 1'b0);

    at_cyc(c0 + 40);
    check("strobes_outstanding", exp_sb.size(), 0);
    check("status_outstanding", exp_st.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_led_sched.md
FLASH_LED_SCHED -- requirements
Module: flash_led_sched

Interface
REQ-001 Parameter DIV0, default 50_000_000, clocks per LED step at speed_sel=0.
REQ-002 Parameter DIV1, default 25_000_000, clocks per step at speed_sel=1.
REQ-003 Parameter DIV2, default 12_500_000, clocks per step at speed_sel=2.
REQ-004 Parameter DIV3, default 6_250_000, clocks per step at speed_sel=3.
REQ-005 Parameter SWEEPS, default 2, full 8-step sweeps per direction in auto mode.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset; asynchronous and active-low.
REQ-008 power_btn  in  1  raw level, already debounced; each rising edge is a power press.
REQ-009 pause_btn  in  1  raw level, already debounced; each rising edge is a pause press.
REQ-010 speed_sel  in  2  step-rate select, read live.
REQ-011 mode_sel  in  2  00 fixed right, 01 fixed left, 10 ping-pong, 11 auto-bounce.
REQ-012 clk_bps  out  1  one-cycle step strobe to the LED shifter.
REQ-013 dir  out  1  0 = shift right, 1 = shift left.
REQ-014 power_now  out  1  1 in RUN or PAUSE.
REQ-015 paused  out  1  1 only in PAUSE.

Function
REQ-016 Each button passes through a 2-FF synchronizer and a rising-edge detector; a press acts on the 3rd clk edge after the raw input rises.
REQ-017 The FSM SHALL have states OFF, RUN and PAUSE.
REQ-018 Power press: OFF->RUN; RUN->OFF; PAUSE->OFF.
REQ-019 Pause press: RUN->PAUSE; PAUSE->RUN; ignored in OFF.
REQ-020 Simultaneous power and pause press: power wins and pause is discarded.
REQ-021 On OFF->RUN, mode_sel is latched, tick/step/sweep counters clear, and dir = 1 if latched mode is 01, else 0.
REQ-022 mode_sel changes take effect only at the next OFF->RUN.
REQ-023 The tick counter runs 0..DIVn-1 in RUN only; clk_bps = 1 for exactly the cycle in which the counter equals DIVn-1, and the counter then wraps to 0.
REQ-024 In PAUSE the tick counter holds its value and clk_bps = 0; PAUSE->RUN resumes counting from the held value.
REQ-025 In OFF the tick counter is 0 and clk_bps = 0.
REQ-026 A speed_sel change, detected against a registered copy, clears the tick counter on that cycle without asserting clk_bps; the new DIVn applies from the next count.
REQ-027 The step counter (0..7) increments on each clk_bps.
REQ-028 Modes 00 and 01: dir is constant; the step counter wraps 7->0.
REQ-029 Mode 10: dir toggles on the 7th clk_bps after entry or after the previous toggle; the toggle is registered together with that strobe.
REQ-030 Mode 11: the sweep counter increments on each 8th clk_bps; dir toggles when the sweep counter reaches SWEEPS, and the sweep counter then clears.
REQ-031 dir changes only in the cycle after a clk_bps or on OFF->RUN; it never changes in PAUSE.

Reset
REQ-032 While rst_n = 0: state OFF, clk_bps=0, dir=0, power_now=0, paused=0, all counters and synchronizer flops 0.
REQ-033 Reset asserted mid-RUN forces the REQ-032 values immediately; after release the block stays OFF until a fresh power press.
REQ-034 A button held high through reset release is not a press; it must fall and rise again.

Verification (DIV0..3 = 16, 8, 4, 3; SWEEPS = 2)
REQ-035 power_btn rises, speed_sel=2, mode 00 -> power_now=1 at 3rd edge; clk_bps every 4 clocks; dir stays 0.
REQ-036 Mode 10, speed 3, power on -> dir toggles after clk_bps #7, #14, #21; exactly 7 strobes between toggles.
REQ-037 Mode 11 -> dir=0 for 16 strobes, toggles to 1 for 16, back to 0.
REQ-038 Pause at tick count 2 of DIV=4, hold 20 clocks, pause again -> no clk_bps while paused; next strobe 1 clock after resume; dir unchanged.
REQ-039 Power and pause pressed on the same edge in RUN -> OFF, paused=0; change speed 2->0 mid-count -> no strobe on the change cycle, next strobe 16 clocks later.
REQ-040 rst_n low mid-RUN with power_btn held high -> all outputs 0 at once; after release, no power_now until power_btn toggles low then high.
